// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: default sizing, register word
// indices and the bus FSM state type.
// Imported by gpio_ctrl and gpio_sync.
package gpio_pkg;

  localparam int N_GPIO_DEF      = 22;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [3:0] IDX_OUT      = 4'd0;
  localparam logic [3:0] IDX_OE       = 4'd1;
  localparam logic [3:0] IDX_FN       = 4'd2;
  localparam logic [3:0] IDX_IN       = 4'd3;
  localparam logic [3:0] IDX_IRQ_EN   = 4'd4;
  localparam logic [3:0] IDX_IRQ_RISE = 4'd5;
  localparam logic [3:0] IDX_IRQ_FALL = 4'd6;
  localparam logic [3:0] IDX_IRQ_PEND = 4'd7;
  localparam logic [3:0] IDX_OUT_SET  = 4'd8;
  localparam logic [3:0] IDX_OUT_CLR  = 4'd9;
  localparam logic [3:0] IDX_OUT_TGL  = 4'd10;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/gpio_sync.sv
// Purpose: per-bit STAGES-deep input synchronizer plus edge detector.
// Latency: sync valid STAGES edges after din changes; rise/fall are
//          combinational from sync and its one-cycle-delayed copy.
// Backpressure: none, free-running.
// Ports: clk, rst (async active-high), din (async pins),
//        sync (synchronized), rise/fall (one-cycle edge strobes).
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int W      = N_GPIO_DEF,
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] chain_q [STAGES];
  logic [W-1:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
      prev_q <= '0;
    end else begin
      chain_q[0] <= din;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
      prev_q <= chain_q[STAGES-1];
    end
  end

  assign sync = chain_q[STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Purpose: register-mapped GPIO controller (out/oe/fn drive, synchronized
//          inputs, per-pin edge interrupts) in front of the IO mux.
// Latency: request at edge k, write lands at edge k, ack/rdata in cycle after k.
// Backpressure: requests arriving during the ack cycle are ignored.
// Ports: clk, rst; bus_req/we/addr/wdata -> bus_rdata/bus_ack;
//        gpio_o/gpio_oe/gpio_fn to mux; gpio_i from mux; irq level.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int N_GPIO      = N_GPIO_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [3:0]        bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ack,
  output logic [N_GPIO-1:0] gpio_o,
  output logic [N_GPIO-1:0] gpio_oe,
  output logic [N_GPIO-1:0] gpio_fn,
  input  logic [N_GPIO-1:0] gpio_i,
  output logic              irq
);

  bus_state_e        state_q, state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [N_GPIO-1:0] out_q, out_d, oe_q, oe_d, fn_q, fn_d;
  logic [N_GPIO-1:0] en_q, en_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [N_GPIO-1:0] pend_q, pend_d;
  logic [N_GPIO-1:0] in_sync, in_rise, in_fall, set_term, wdat, rd_sel;
  logic              acc, wr;

  gpio_sync #(.W(N_GPIO), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (gpio_i),
    .sync (in_sync),
    .rise (in_rise),
    .fall (in_fall)
  );

  // Bits above N_GPIO are write-ignored.
  if (N_GPIO < 32) begin : g_wpad
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^bus_wdata[31:N_GPIO];
  end

  assign wdat     = bus_wdata[N_GPIO-1:0];
  assign acc      = (state_q == BUS_IDLE) && bus_req;
  assign wr       = acc && bus_we;
  // Edges latch regardless of IRQ_EN so software can poll masked pins.
  assign set_term = (in_rise & rise_en_q) | (in_fall & fall_en_q);

  always_comb begin
    state_d   = state_q;
    rdata_d   = '0;
    out_d     = out_q;
    oe_d      = oe_q;
    fn_d      = fn_q;
    en_d      = en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    pend_d    = pend_q | set_term;
    rd_sel    = '0;

    unique case (bus_addr)
      IDX_OUT:      rd_sel = out_q;
      IDX_OE:       rd_sel = oe_q;
      IDX_FN:       rd_sel = fn_q;
      IDX_IN:       rd_sel = in_sync;
      IDX_IRQ_EN:   rd_sel = en_q;
      IDX_IRQ_RISE: rd_sel = rise_en_q;
      IDX_IRQ_FALL: rd_sel = fall_en_q;
      IDX_IRQ_PEND: rd_sel = pend_q;
      default:      rd_sel = '0;
    endcase

    if (wr) begin
      unique case (bus_addr)
        IDX_OUT:      out_d     = wdat;
        IDX_OE:       oe_d      = wdat;
        IDX_FN:       fn_d      = wdat;
        IDX_IRQ_EN:   en_d      = wdat;
        IDX_IRQ_RISE: rise_en_d = wdat;
        IDX_IRQ_FALL: fall_en_d = wdat;
        // A new edge in the same cycle as the clear keeps the bit set.
        IDX_IRQ_PEND: pend_d    = (pend_q & ~wdat) | set_term;
        IDX_OUT_SET:  out_d     = out_q | wdat;
        IDX_OUT_CLR:  out_d     = out_q & ~wdat;
        IDX_OUT_TGL:  out_d     = out_q ^ wdat;
        default:      ;
      endcase
    end

    unique case (state_q)
      BUS_IDLE: begin
        if (acc) begin
          state_d = BUS_ACK;
          if (!bus_we) rdata_d[N_GPIO-1:0] = rd_sel;
        end
      end
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BUS_IDLE;
      rdata_q   <= '0;
      out_q     <= '0;
      oe_q      <= '0;
      fn_q      <= '0;
      en_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      fn_q      <= fn_d;
      en_q      <= en_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
    end
  end

  assign bus_ack   = (state_q == BUS_ACK);
  assign bus_rdata = rdata_q;
  assign gpio_o    = out_q;
  assign gpio_oe   = oe_q;
  assign gpio_fn   = fn_q;
  assign irq       = |(pend_q & en_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: register access, OUT set/clr/toggle,
// input synchronizer latency, edge interrupts, W1C race and mid-access reset.
module tb_gpio_ctrl;

  localparam int N = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bus_req = 1'b0;
  logic          bus_we = 1'b0;
  logic [3:0]    bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic [31:0]   bus_rdata;
  logic          bus_ack;
  logic [N-1:0]  gpio_o, gpio_oe, gpio_fn;
  logic [N-1:0]  gpio_i = '0;
  logic          irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  gpio_ctrl #(.N_GPIO(N), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .gpio_o    (gpio_o),
    .gpio_oe   (gpio_oe),
    .gpio_fn   (gpio_fn),
    .gpio_i    (gpio_i),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Request on one negedge, ack must be present on the next and gone on the one after.
  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0;
    chk($sformatf("wr%0d_ack", a), {31'b0, bus_ack}, 32'd1);
    @(negedge clk);
    chk($sformatf("wr%0d_ack_drop", a), {31'b0, bus_ack}, 32'd0);
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_req = 1'b0;
    chk($sformatf("rd%0d_ack", a), {31'b0, bus_ack}, 32'd1);
    d = bus_rdata;
    @(negedge clk);
    chk($sformatf("rd%0d_ack_drop", a), {31'b0, bus_ack}, 32'd0);
    chk($sformatf("rd%0d_rdata_idle", a), bus_rdata, 32'd0);
  endtask

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_gpio_o", 32'(gpio_o), 32'h0);
    chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("rst_gpio_fn", 32'(gpio_fn), 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_ack", {31'b0, bus_ack}, 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    for (int i = 0; i < 16; i++) begin
      bus_rd(4'(i), rd);
      chk($sformatf("rst_reg%0d", i), rd, 32'h0);
    end

    // ---- OUT and its set/clear/toggle aliases ----
    bus_wr(4'd0, 32'h0000F0);
    bus_wr(4'd8, 32'h00000F);
    bus_wr(4'd9, 32'h000030);
    bus_wr(4'd10, 32'h300000);
    bus_rd(4'd0, rd);
    chk("out_rb", rd, 32'h3000CF);
    chk("gpio_o", 32'(gpio_o), 32'h3000CF);
    bus_rd(4'd8, rd);
    chk("out_set_rd0", rd, 32'h0);

    // ---- OE/FN, bits above N_GPIO ignored ----
    bus_wr(4'd1, 32'hFFFF_FFFF);
    bus_rd(4'd1, rd);
    chk("oe_rb_trunc", rd, 32'h003F_FFFF);
    chk("gpio_oe", 32'(gpio_oe), 32'h003F_FFFF);
    bus_wr(4'd2, 32'h0000_0155);
    chk("gpio_fn", 32'(gpio_fn), 32'h0000_0155);
    bus_wr(4'd12, 32'h1234_5678);
    bus_rd(4'd12, rd);
    chk("unmapped_rd0", rd, 32'h0);

    // ---- rising edge on pin 5, enabled: IN latency and irq latency ----
    bus_wr(4'd5, 32'h20);
    bus_wr(4'd4, 32'h20);
    @(negedge clk);
    gpio_i = N'(32'h20);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 4'd3;   // sampled at edge k
    @(negedge clk);
    bus_req = 1'b0;
    chk("in_k_ack", {31'b0, bus_ack}, 32'd1);
    chk("in_before_k", bus_rdata, 32'h0);
    chk("irq_k", {31'b0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_k1", {31'b0, irq}, 32'd0);
    bus_req = 1'b1; bus_addr = 4'd3;                  // sampled at edge k+2
    @(negedge clk);
    bus_req = 1'b0;
    chk("in_after_k1", bus_rdata, 32'h20);
    chk("irq_k2", {31'b0, irq}, 32'd1);
    bus_rd(4'd7, rd);
    chk("pend_rise", rd, 32'h20);
    bus_wr(4'd7, 32'h20);
    chk("irq_after_w1c", {31'b0, irq}, 32'd0);
    gpio_i = '0;                                      // falling edge, not enabled
    repeat (4) @(negedge clk);
    bus_rd(4'd7, rd);
    chk("pend_fall_masked", rd, 32'h0);

    // ---- masked edge still latches ----
    bus_wr(4'd4, 32'h0);
    @(negedge clk);
    gpio_i = N'(32'h20);
    repeat (4) @(negedge clk);
    bus_rd(4'd7, rd);
    chk("pend_masked", rd, 32'h20);
    chk("irq_masked", {31'b0, irq}, 32'd0);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 4'd4; bus_wdata = 32'h20;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0;
    chk("irq_en_next", {31'b0, irq}, 32'd1);

    // ---- W1C colliding with a new falling edge: set wins ----
    bus_wr(4'd6, 32'h20);
    @(negedge clk);
    gpio_i = '0;                                      // before edge k
    @(negedge clk);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 4'd7; bus_wdata = 32'h20;  // edge k+2
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0;
    chk("race_ack", {31'b0, bus_ack}, 32'd1);
    bus_rd(4'd7, rd);
    chk("race_pend", rd, 32'h20);
    chk("race_irq", {31'b0, irq}, 32'd1);
    bus_wr(4'd7, 32'h20);
    bus_rd(4'd7, rd);
    chk("w1c_clear", rd, 32'h0);
    chk("w1c_irq", {31'b0, irq}, 32'd0);

    // ---- reset during an access ----
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 4'd0; bus_wdata = 32'hABC;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus_req = 1'b0; bus_we = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack", {31'b0, bus_ack}, 32'd0);
    chk("rst_mid_gpio_o", 32'(gpio_o), 32'h0);
    @(negedge clk);
    chk("rst_mid_ack2", {31'b0, bus_ack}, 32'd0);
    rst = 1'b0;
    chk("rst2_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("rst2_gpio_fn", 32'(gpio_fn), 32'h0);
    chk("rst2_irq", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 11; i++) begin
      bus_rd(4'(i), rd);
      chk($sformatf("rst2_reg%0d", i), rd, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
